pio_pwm_gen: RTL and testbench
==============================

Name: pio_pwm_gen

Overview:
- Consumes the 32-bit control word driven by the processor output PIO (`out_port`) and generates a glitch-free PWM waveform.
- Detects changes in the word and double-buffers the new settings. New settings take effect only at a period boundary, so software writes never produce runt pulses.
- Sits directly downstream of the PIO, in the same clock domain, and drives a board pin plus status strobes.

Parameters:
- CNT_W, 12, width of the period and duty fields and of the period counter.
- PRE_W, 6, width of the prescale field and of the prescale counter.
- Legality: 2 + PRE_W + 2*CNT_W must be ≤ 32. Fields pack from bit 31 downward; leftover LSBs are reserved and ignored.

Ports:
- clk  in  1  system clock, single domain.
- reset_n  in  1  synchronous active-low reset.
- ctrl_word  in  32  PIO output word. With default parameters: [31] enable, [30] invert, [29:24] prescale, [23:12] period, [11:0] duty.
- pwm_out  out  1  registered PWM output.
- period_strobe  out  1  one-cycle pulse when the period counter wraps.
- update_ack  out  1  one-cycle pulse when the shadow settings are loaded.
- armed  out  1  high once `ctrl_word` has changed at least once since reset.

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge):
  - ctrl_q ← ctrl_word, so the PIO's non-zero reset value is never treated as a change.
  - staged, shadow, pre_cnt and per_cnt ← 0; pending ← 0.
  - armed ← 0, pwm_out ← 0, period_strobe ← 0, update_ack ← 0.
- Reset mid-operation: pwm_out goes low on the reset edge. Previous settings are discarded, and the block rearms only on the next word change.
- Change detect:
  - ctrl_q ← ctrl_word every cycle.
  - change = (ctrl_word ≠ ctrl_q).
  - On change: staged ← ctrl_word, pending ← 1, armed ← 1 (sticky until reset).
- Shadow load: occurs when pending=1 and (shadow.enable=0 or period_end).
  - shadow ← staged, pending ← 0, update_ack=1 on the following cycle.
  - If change and load occur in the same cycle: shadow takes the old staged value, staged takes the new word, and pending stays 1 (set wins).
- Prescaler:
  - While shadow.enable=0: pre_cnt and per_cnt are held at 0.
  - Otherwise pre_cnt counts 0..PRE; tick = (pre_cnt == PRE), and pre_cnt wraps to 0 on tick.
  - PRE=0 gives a tick every cycle.
- Period counter:
  - On tick, per_cnt counts 0..PERIOD and wraps to 0.
  - period_end = tick & (per_cnt == PERIOD).
  - One period lasts (PERIOD+1)*(PRE+1) clocks.
  - period_strobe is registered, so it is high the cycle after period_end.
  - On a shadow load, both counters restart at 0.
- Output:
  - raw = (per_cnt < DUTY).
  - pwm_out ← shadow.enable ? (raw ^ invert) : shadow.invert.
  - Latency: 1 clock from the counter state.
  - DUTY=0: output constantly inactive.
  - DUTY > PERIOD: output constantly active; period_strobe continues.
- Enable/disable timing:
  - Enabling from the disabled state loads immediately; the counters start at 0 in the next cycle.
  - Disabling, or any other change while enabled, waits for period_end.
- Arithmetic: all counter comparisons are unsigned at CNT_W/PRE_W bits; there is no overflow beyond the field width.
- Reserved bits: a change in reserved bits still sets pending and produces update_ack.

Test Plan:
- Reset value: hold ctrl_word=0xBADC0C0A through reset, release, run 200 cycles → pwm_out=0, armed=0, no update_ack, no period_strobe.
- Basic waveform: write 0x80009003 (PRE=0, PERIOD=9, DUTY=3) → update_ack one cycle later. Then pwm_out is high 3 clocks / low 7 clocks repeating, and period_strobe fires every 10 clocks.
- Deferred update: while running 0x80009003, write 0x80009007 when per_cnt=5 → current period is unchanged. update_ack coincides with the wrap, and the next period is high for 7 clocks.
- Prescale and saturation:
  - 0x82004002 → tick every 3 clocks; period 15 clocks, high 6 clocks.
  - 0x80003005 → pwm_out constantly 1; period_strobe every 4 clocks.
- Invert/disable: 0xC0009000 → pwm_out constantly 1. Then write 0x40009000 → at the next wrap, counters freeze at 0 and pwm_out stays at idle level 1.
- Simultaneous events: change the word on the exact period_end cycle → the old staged word loads, pending remains set, and the newest word loads at the following wrap. Separately, assert reset mid-period → pwm_out=0 the next cycle.

Source files
------------

// File: rtl/pio_pwm_gen_if.sv
// pio_pwm_gen_if: PIO control word in, PWM pin and status strobes out
interface pio_pwm_gen_if;
  logic [31:0] ctrl_word;
  logic pwm_out;
  logic period_strobe;
  logic update_ack;
  logic armed;
  modport master(output ctrl_word, input pwm_out, period_strobe, update_ack, armed);
  modport slave(input ctrl_word, output pwm_out, period_strobe, update_ack, armed);
endinterface

// File: rtl/pio_pwm_gen.sv
// pio_pwm_gen: double-buffered glitch-free PWM driven by a PIO control word, updates only at period boundaries
module pio_pwm_gen #(
  parameter int CNT_W = 12,
  parameter int PRE_W = 6
) (
  input logic clk,
  input logic reset_n,
  pio_pwm_gen_if.slave bus
);
  localparam int PRE_LO = 30 - PRE_W;
  localparam int PER_LO = PRE_LO - CNT_W;
  logic [31:0] ctrl_q, ctrl_d, staged_q, staged_d, shadow_q, shadow_d;
  logic pending_q, pending_d, armed_q, armed_d, pwm_q, pwm_d, strobe_q, strobe_d, ack_q, ack_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d, pre;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, period, duty;
  logic en, inv, change, tick, period_end, load;
  always_comb begin
    en = shadow_q[31];
    inv = shadow_q[30];
    pre = shadow_q[29 -: PRE_W];
    period = shadow_q[PRE_LO-1 -: CNT_W];
    duty = shadow_q[PER_LO-1 -: CNT_W];
    change = bus.ctrl_word != ctrl_q;
    tick = en && (pre_cnt_q == pre);
    period_end = tick && (per_cnt_q == period);
    load = pending_q && (!en || period_end);
    ctrl_d = bus.ctrl_word;
    staged_d = change ? bus.ctrl_word : staged_q;
    pending_d = change || (pending_q && !load);
    shadow_d = load ? staged_q : shadow_q;
    armed_d = armed_q || change;
    pre_cnt_d = (load || !en || tick) ? '0 : pre_cnt_q + 1'b1;
    per_cnt_d = (load || !en || period_end) ? '0 : tick ? per_cnt_q + 1'b1 : per_cnt_q;
    pwm_d = en ? ((per_cnt_q < duty) ^ inv) : inv;
    strobe_d = period_end;
    ack_d = load;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q <= bus.ctrl_word;
      staged_q <= '0;
      shadow_q <= '0;
      pending_q <= 1'b0;
      armed_q <= 1'b0;
      pwm_q <= 1'b0;
      strobe_q <= 1'b0;
      ack_q <= 1'b0;
      pre_cnt_q <= '0;
      per_cnt_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      staged_q <= staged_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      armed_q <= armed_d;
      pwm_q <= pwm_d;
      strobe_q <= strobe_d;
      ack_q <= ack_d;
      pre_cnt_q <= pre_cnt_d;
      per_cnt_q <= per_cnt_d;
    end
  end
  assign bus.pwm_out = pwm_q;
  assign bus.period_strobe = strobe_q;
  assign bus.update_ack = ack_q;
  assign bus.armed = armed_q;
endmodule

// File: tb/tb_pio_pwm_gen.sv
// tb_pio_pwm_gen: directed writes push expected per-cycle outputs {armed,ack,strobe,pwm} into a scoreboard checked by a monitor
module tb_pio_pwm_gen;
  typedef struct {
    int cyc;
    logic [3:0] exp;
    logic [3:0] mask;
    string tag;
  } rec_t;
  logic clk = 1'b0;
  logic reset_n;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  rec_t q[$];
  rec_t mr;
  logic [3:0] act;
  pio_pwm_gen_if bus_if();
  pio_pwm_gen dut(.clk(clk), .reset_n(reset_n), .bus(bus_if));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void push(int c, logic [3:0] e, logic [3:0] m, string t);
    rec_t r;
    int i = 0;
    r.cyc = c;
    r.exp = e;
    r.mask = m;
    r.tag = t;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, r);
  endfunction
  function automatic void run(int base, int p, int per, int d, bit inv, int k0, int k1, string t);
    for (int k = k0; k <= k1; k++) begin
      int j = k - 1;
      int pc = (j / (p + 1)) % (per + 1);
      bit pw = (pc < d) ^ inv;
      bit st = (j % (p + 1) == p) && (pc == per);
      push(base + k, {2'b10, st, pw}, 4'hF, t);
    end
  endfunction
  task automatic go(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    act = {bus_if.armed, bus_if.update_ack, bus_if.period_strobe, bus_if.pwm_out};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mr = q.pop_front();
      total++;
      if (mr.cyc != cyc || (act & mr.mask) !== (mr.exp & mr.mask)) begin
        bad++;
        $display("FAIL %s cyc=%0d exp_cyc=%0d got=%b want=%b mask=%b", mr.tag, cyc, mr.cyc, act, mr.exp, mr.mask);
      end
    end
  end
  initial begin
    int b, b2, b3, b4, b5, b6, b7, b8, b9, w;
    reset_n = 1'b0;
    bus_if.ctrl_word = 32'hBADC0C0A;
    for (int c = 1; c <= 203; c++) push(c, 4'b0000, 4'hF, "reset_idle");
    go(3);
    reset_n = 1'b1;
    go(203);
    bus_if.ctrl_word = 32'h80009003;
    b = 205;
    push(204, 4'b1000, 4'hF, "arm");
    push(b, 4'b1100, 4'hF, "ack_basic");
    run(b, 0, 9, 3, 1'b0, 1, 29, "basic");
    go(b + 25);
    bus_if.ctrl_word = 32'h80009007;
    b2 = b + 30;
    push(b2, 4'b1110, 4'hF, "ack_deferred");
    run(b2, 0, 9, 7, 1'b0, 1, 39, "deferred");
    go(b2 + 30);
    bus_if.ctrl_word = 32'h82004002;
    b3 = b2 + 40;
    push(b3, 4'b1110, 4'hF, "ack_prescale");
    run(b3, 2, 4, 2, 1'b0, 1, 29, "prescale");
    go(b3 + 15);
    bus_if.ctrl_word = 32'h80003005;
    b4 = b3 + 30;
    push(b4, 4'b1110, 4'hF, "ack_sat");
    run(b4, 0, 3, 5, 1'b0, 1, 11, "saturate");
    go(b4 + 8);
    bus_if.ctrl_word = 32'hC0009000;
    b5 = b4 + 12;
    push(b5, 4'b1111, 4'hF, "ack_invert");
    run(b5, 0, 9, 0, 1'b1, 1, 19, "invert");
    go(b5 + 15);
    bus_if.ctrl_word = 32'h40009000;
    b6 = b5 + 20;
    push(b6, 4'b1111, 4'hF, "ack_disable");
    for (int c = b6 + 1; c <= b6 + 30; c++) push(c, 4'b1001, 4'hF, "disabled_idle");
    go(b6 + 30);
    bus_if.ctrl_word = 32'h80009003;
    b7 = b6 + 32;
    push(b6 + 31, 4'b1001, 4'hF, "reenable_wait");
    push(b7, 4'b1101, 4'hF, "ack_reenable");
    run(b7, 0, 9, 3, 1'b0, 1, 19, "reenable");
    go(b7 + 12);
    bus_if.ctrl_word = 32'h80009005;
    go(b7 + 19);
    bus_if.ctrl_word = 32'h80009007;
    b8 = b7 + 20;
    push(b8, 4'b1110, 4'hF, "ack_old_staged");
    run(b8, 0, 9, 5, 1'b0, 1, 9, "old_staged");
    b9 = b8 + 10;
    push(b9, 4'b1110, 4'hF, "ack_newest");
    run(b9, 0, 9, 7, 1'b0, 1, 14, "newest");
    go(b9 + 14);
    reset_n = 1'b0;
    for (int c = b9 + 15; c <= b9 + 40; c++) push(c, 4'b0000, 4'hF, "mid_reset");
    go(b9 + 15);
    reset_n = 1'b1;
    go(b9 + 40);
    w = b9 + 40;
    bus_if.ctrl_word = 32'h80009003;
    push(w + 1, 4'b1000, 4'hF, "rearm");
    push(w + 2, 4'b1100, 4'hF, "ack_rearm");
    run(w + 2, 0, 9, 3, 1'b0, 1, 12, "rearm_run");
    go(w + 16);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
